// File: rtl/csr_commit_unit_pkg.sv
// Shared command encoding, FSM state constants and side-effect CSR list for csr_commit_unit.
// Optional performance counters in the top are enabled with CSR_COMMIT_PERF_EN.
package csr_commit_unit_pkg;

   typedef enum logic [1:0] {
      CSR_READ  = 2'd0,
      CSR_WRITE = 2'd1,
      CSR_SET   = 2'd2,
      CSR_CLEAR = 2'd3
   } csr_cmd_e;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_REQ  = 3'd1;
   localparam logic [2:0] ST_RD_WAIT = 3'd2;
   localparam logic [2:0] ST_WR_REQ  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // Writing any of these changes machine state the pipeline has already speculated on.
   localparam int N_SIDE_EFFECT = 4;
   localparam logic [11:0] SIDE_EFFECT_CSRS [N_SIDE_EFFECT] =
      '{12'h180, 12'h300, 12'h100, 12'h7C0};

   function automatic logic is_side_effect_csr(input logic [11:0] addr);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_SIDE_EFFECT; i++) begin
         if (addr == SIDE_EFFECT_CSRS[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/csr_commit_unit_watchdog.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count would reach TIMEOUT_CYCLES.
module csr_commit_watchdog #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (enable_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/csr_commit_unit.sv
// Executes one retired CSR instruction as a read-modify-write on the CSR register-file port.
// Define CSR_COMMIT_PERF_EN to build the committed-op and handshake-stall counters.
module csr_commit_unit
   import csr_commit_unit_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            valid_i,
   input  logic [1:0]      op_i,
   input  logic [11:0]     addr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [1:0]      priv_lvl_i,
   input  logic            commit_i,
   output logic            ready_o,
   output logic            csr_req_o,
   output logic            csr_we_o,
   output logic [11:0]     csr_addr_o,
   output logic [XLEN-1:0] csr_wdata_o,
   input  logic            csr_gnt_i,
   input  logic            csr_rvalid_i,
   input  logic [XLEN-1:0] csr_rdata_i,
   output logic            done_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            exception_o,
   output logic            flush_req_o,
   output logic [31:0]     perf_ops_o,
   output logic [31:0]     perf_stall_o
);

   logic [2:0]      state_q, state_d;
   csr_cmd_e        op_q;
   logic [11:0]     addr_q;
   logic [XLEN-1:0] wdata_q, old_q, new_q, new_val;
   logic            exc_q, wrote_q;
   logic            start, illegal, waiting, wd_expired;

   assign start   = (state_q == ST_IDLE) && commit_i && valid_i && !flush_i;
   assign illegal = ((csr_cmd_e'(op_i) != CSR_READ) && (addr_i[11:10] == 2'b11))
                 || (addr_i[9:8] > priv_lvl_i);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      waiting = 1'b0;
      case (state_q)
         ST_RD_REQ, ST_WR_REQ: waiting = !csr_gnt_i;
         ST_RD_WAIT:           waiting = !csr_rvalid_i;
         default:              waiting = 1'b0;
      endcase
   end

   csr_commit_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (state_d != state_q),
      .enable_i  (waiting),
      .expired_o (wd_expired)
   );

   always_comb begin
      new_val = wdata_q;
      case (op_q)
         CSR_SET:   new_val = csr_rdata_i | wdata_q;
         CSR_CLEAR: new_val = csr_rdata_i & ~wdata_q;
         default:   new_val = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = illegal ? ST_DONE : ST_RD_REQ;
         end
         ST_RD_REQ: begin
            if (csr_gnt_i)       state_d = ST_RD_WAIT;
            else if (wd_expired) state_d = ST_DONE;
         end
         ST_RD_WAIT: begin
            if (csr_rvalid_i)    state_d = (op_q == CSR_READ) ? ST_DONE : ST_WR_REQ;
            else if (wd_expired) state_d = ST_DONE;
         end
         ST_WR_REQ: begin
            if (csr_gnt_i || wd_expired) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A timed-out op never reaches WR_REQ's grant, so wrote_q stays clear and no flush is requested.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q    <= CSR_READ;
         addr_q  <= '0;
         wdata_q <= '0;
         old_q   <= '0;
         new_q   <= '0;
         exc_q   <= 1'b0;
         wrote_q <= 1'b0;
      end else begin
         if (start) begin
            op_q    <= csr_cmd_e'(op_i);
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            exc_q   <= illegal;
            wrote_q <= 1'b0;
         end
         if ((state_q == ST_RD_WAIT) && csr_rvalid_i) begin
            old_q <= csr_rdata_i;
            new_q <= new_val;
         end
         if ((state_q == ST_WR_REQ) && csr_gnt_i) wrote_q <= 1'b1;
         if (wd_expired) exc_q <= 1'b1;
      end
   end

   assign ready_o     = (state_q == ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign csr_req_o   = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
   assign csr_we_o    = (state_q == ST_WR_REQ);
   assign csr_addr_o  = csr_req_o ? addr_q : '0;
   assign csr_wdata_o = csr_we_o ? new_q : '0;
   assign rdata_o     = done_o ? old_q : '0;
   assign exception_o = done_o && exc_q;
   assign flush_req_o = done_o && wrote_q && is_side_effect_csr(addr_q);

`ifdef CSR_COMMIT_PERF_EN
   logic [31:0] perf_ops_q, perf_stall_q;
   logic        stall_cycle;

   assign stall_cycle = (csr_req_o && !csr_gnt_i) || ((state_q == ST_RD_WAIT) && !csr_rvalid_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_ops_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (done_o && !exc_q && (perf_ops_q != '1))    perf_ops_q   <= perf_ops_q + 32'd1;
         if (stall_cycle && (perf_stall_q != '1))       perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_ops_o   = perf_ops_q;
   assign perf_stall_o = perf_stall_q;
`else
   assign perf_ops_o   = '0;
   assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_csr_commit_unit.sv
// Randomized bench for csr_commit_unit: a transaction-level model plus a CSR register-file
// responder with variable grant/rvalid latency; directed cases pin the model with literals.
module tb_csr_commit_unit;

   localparam int XLEN = 64;
   localparam int TMO  = 16;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            flush_i, valid_i, commit_i;
   logic [1:0]      op_i, priv_lvl_i;
   logic [11:0]     addr_i;
   logic [XLEN-1:0] wdata_i;
   logic            ready_o, csr_req_o, csr_we_o;
   logic [11:0]     csr_addr_o;
   logic [XLEN-1:0] csr_wdata_o;
   logic            csr_gnt_i, csr_rvalid_i;
   logic [XLEN-1:0] csr_rdata_i;
   logic            done_o, exception_o, flush_req_o;
   logic [XLEN-1:0] rdata_o;
   logic [31:0]     perf_ops_o, perf_stall_o;

   csr_commit_unit #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
      .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .priv_lvl_i(priv_lvl_i),
      .commit_i(commit_i), .ready_o(ready_o), .csr_req_o(csr_req_o), .csr_we_o(csr_we_o),
      .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o), .csr_gnt_i(csr_gnt_i),
      .csr_rvalid_i(csr_rvalid_i), .csr_rdata_i(csr_rdata_i), .done_o(done_o),
      .rdata_o(rdata_o), .exception_o(exception_o), .flush_req_o(flush_req_o),
      .perf_ops_o(perf_ops_o), .perf_stall_o(perf_stall_o)
   );

   always #5 clk_i = ~clk_i;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // CSR register file contents seen by the responder.
   logic [63:0] mem [logic [11:0]];

   function automatic logic [63:0] mem_rd(input logic [11:0] a);
      if (mem.exists(a)) return mem[a];
      return {52'h0, a} ^ 64'hA5A5_0000_0000_0000;
   endfunction

   function automatic logic side_effect(input logic [11:0] a);
      return (a == 12'h180) || (a == 12'h300) || (a == 12'h100) || (a == 12'h7C0);
   endfunction

   // ---------------- register-file responder ----------------
   bit          rnd_resp = 1'b0;
   int          gnt_dly  = 0;
   int          rv_dly   = 0;
   logic        gnt_pend, rv_arm;
   int          gnt_cnt, rv_cnt;
   logic [11:0] rv_addr;

   function automatic int pick(input int fixed);
      if (!rnd_resp) return fixed;
      if ($urandom_range(0, 24) == 0) return 20;
      return int'($urandom_range(0, 3));
   endfunction

   initial begin
      csr_gnt_i = 1'b0; csr_rvalid_i = 1'b0; csr_rdata_i = '0;
      gnt_pend = 1'b0; rv_arm = 1'b0; gnt_cnt = 0; rv_cnt = 0; rv_addr = '0;
      forever begin
         @(posedge clk_i); #1;
         csr_gnt_i = 1'b0; csr_rvalid_i = 1'b0; csr_rdata_i = {$urandom, $urandom};
         if (!rst_ni || done_o) begin
            gnt_pend = 1'b0; rv_arm = 1'b0;
         end else begin
            if (rv_arm) begin
               if (rv_cnt == 0) begin
                  csr_rvalid_i = 1'b1; csr_rdata_i = mem_rd(rv_addr); rv_arm = 1'b0;
               end else rv_cnt--;
            end
            if (csr_req_o) begin
               if (!gnt_pend) begin gnt_pend = 1'b1; gnt_cnt = pick(gnt_dly); end
               if (gnt_cnt == 0) begin
                  csr_gnt_i = 1'b1; gnt_pend = 1'b0;
                  if (csr_we_o) mem[csr_addr_o] = csr_wdata_o;
                  else begin rv_arm = 1'b1; rv_cnt = pick(rv_dly); rv_addr = csr_addr_o; end
               end else gnt_cnt--;
            end
         end
      end
   end

   // ---------------- transaction-level model and compare ----------------
   logic        m_act, m_due, m_exc_e, m_flush_e;
   int          m_phase, m_wait, m_op;   // phase: 0 await read grant, 1 await data, 2 await write grant
   logic [11:0] m_addr;
   logic [63:0] m_old, m_new;
   logic [31:0] m_ops, m_stall;
   int          acc_cyc = 0, last_done_cyc = 0, done_cnt = 0, req_cycles = 0;
   logic [63:0] last_rdata = '0;
   logic        last_exc = 1'b0, last_flush = 1'b0;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         m_act = 1'b0; m_due = 1'b0; m_ops = '0; m_stall = '0; m_wait = 0;
         check("reset_ready", ready_o, 1);
         check("reset_done", done_o, 0);
         check("reset_req", csr_req_o, 0);
         check("reset_perf_ops", perf_ops_o, 0);
         check("reset_perf_stall", perf_stall_o, 0);
      end else begin
`ifdef CSR_COMMIT_PERF_EN
         check("perf_ops", perf_ops_o, m_ops);
         check("perf_stall", perf_stall_o, m_stall);
`else
         check("perf_ops_tied", perf_ops_o, 0);
         check("perf_stall_tied", perf_stall_o, 0);
`endif
         if (csr_req_o) req_cycles++;
         check("done", done_o, m_due);
         if (m_due) begin
            check("exception", exception_o, m_exc_e);
            check("flush_req", flush_req_o, m_flush_e);
            check("ready_in_done", ready_o, 0);
            check("req_in_done", csr_req_o, 0);
            if (!m_exc_e) check("rdata", rdata_o, m_old);
            last_rdata = rdata_o; last_exc = exception_o; last_flush = flush_req_o;
            last_done_cyc = cyc; done_cnt++;
            if (!m_exc_e && m_ops != 32'hFFFF_FFFF) m_ops++;
            m_due = 1'b0; m_act = 1'b0;
         end else if (m_act) begin
            check("ready_busy", ready_o, 0);
            if (m_phase == 1) begin
               check("req_in_read_wait", csr_req_o, 0);
               if (csr_rvalid_i) begin
                  m_wait = 0;
                  if (m_op == 0) begin m_due = 1'b1; m_exc_e = 1'b0; m_flush_e = 1'b0; end
                  else m_phase = 2;
               end else m_wait++;
            end else begin
               check("req", csr_req_o, 1);
               check("we", csr_we_o, (m_phase == 2) ? 1 : 0);
               check("addr", csr_addr_o, m_addr);
               if (m_phase == 2) check("wdata", csr_wdata_o, m_new);
               if (csr_gnt_i) begin
                  m_wait = 0;
                  if (m_phase == 0) m_phase = 1;
                  else begin m_due = 1'b1; m_exc_e = 1'b0; m_flush_e = side_effect(m_addr); end
               end else m_wait++;
            end
            if (!csr_req_o ? !csr_rvalid_i && m_phase == 1 : !csr_gnt_i)
               if (m_stall != 32'hFFFF_FFFF) m_stall++;
            if (m_wait == TMO) begin m_due = 1'b1; m_exc_e = 1'b1; m_flush_e = 1'b0; end
         end else begin
            check("ready_idle", ready_o, 1);
            check("req_idle", csr_req_o, 0);
            if (commit_i && valid_i && !flush_i) begin
               m_act = 1'b1; m_addr = addr_i; m_op = int'(op_i); acc_cyc = cyc;
               m_old = mem_rd(addr_i); m_phase = 0; m_wait = 0;
               case (m_op)
                  1:       m_new = wdata_i;
                  2:       m_new = m_old | wdata_i;
                  3:       m_new = m_old & ~wdata_i;
                  default: m_new = m_old;
               endcase
               if ((m_op != 0 && addr_i[11:10] == 2'b11) || (addr_i[9:8] > priv_lvl_i)) begin
                  m_due = 1'b1; m_exc_e = 1'b1; m_flush_e = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd,
                        input logic [1:0] priv, input logic fl);
      valid_i = 1'b1; commit_i = 1'b1; flush_i = fl;
      op_i = op; addr_i = addr; wdata_i = wd; priv_lvl_i = priv;
      @(posedge clk_i); #1;
      valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic wait_done(input int start_cnt);
      int n = 0;
      while (done_cnt == start_cnt && n < 100) begin @(posedge clk_i); #1; n++; end
      check("op_completes", (done_cnt != start_cnt) ? 1 : 0, 1);
   endtask

   logic [11:0] addr_tab [12] = '{12'h340, 12'h341, 12'h180, 12'h300, 12'h100, 12'h7C0,
                                  12'h105, 12'hC00, 12'h3A0, 12'h010, 12'hF11, 12'h200};

   initial begin
      int d0, r0;
      rst_ni = 1'b0; valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0;
      op_i = '0; addr_i = '0; wdata_i = '0; priv_lvl_i = 2'd3;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // SET 0x340: old 0xF0 | 0x0F -> 0xFF, done in the 5th cycle counting the commit cycle
      mem[12'h340] = 64'hF0;
      d0 = done_cnt; issue(2'd2, 12'h340, 64'h0F, 2'd3, 1'b0); wait_done(d0);
      check("set_rdata", last_rdata, 64'hF0);
      check("set_exc", last_exc, 0);
      check("set_flush", last_flush, 0);
      check("set_written", mem_rd(12'h340), 64'hFF);
      check("set_latency", 64'(last_done_cyc - acc_cyc), 4);

      // Privilege violation and read-only write: exception, no request
      r0 = req_cycles; d0 = done_cnt; issue(2'd1, 12'h300, 64'h1, 2'd1, 1'b0); wait_done(d0);
      check("priv_exc", last_exc, 1);
      check("priv_no_req", 64'(req_cycles - r0), 0);
      check("priv_latency", 64'(last_done_cyc - acc_cyc), 1);
      r0 = req_cycles; d0 = done_cnt; issue(2'd1, 12'hC00, 64'h1, 2'd3, 1'b0); wait_done(d0);
      check("ro_exc", last_exc, 1);
      check("ro_no_req", 64'(req_cycles - r0), 0);

      // Side-effect CSR write requests a pipeline flush
      d0 = done_cnt; issue(2'd1, 12'h180, 64'h8000_0000_0000_0001, 2'd3, 1'b0); wait_done(d0);
      check("satp_flush", last_flush, 1);
      check("satp_exc", last_exc, 0);
      check("satp_written", mem_rd(12'h180), 64'h8000_0000_0000_0001);

      // flush_i with commit_i: nothing starts
      d0 = done_cnt; issue(2'd0, 12'h340, 64'h0, 2'd3, 1'b1);
      repeat (4) @(posedge clk_i); #1;
      check("flush_no_start", 64'(done_cnt - d0), 0);
      check("flush_ready", ready_o, 1);

      // flush_i during the read wait is ignored
      rv_dly = 2;
      d0 = done_cnt; issue(2'd0, 12'h340, 64'h0, 2'd3, 1'b0);
      @(posedge clk_i); #1 flush_i = 1'b1;
      repeat (2) @(posedge clk_i); #1 flush_i = 1'b0;
      wait_done(d0);
      check("late_flush_exc", last_exc, 0);
      check("late_flush_rdata", last_rdata, 64'hFF);
      rv_dly = 0;

      // Grant withheld: timeout after exactly 16 RD_REQ cycles, then a normal CLEAR
      gnt_dly = 100;
      d0 = done_cnt; issue(2'd0, 12'h340, 64'h0, 2'd3, 1'b0); wait_done(d0);
      check("timeout_exc", last_exc, 1);
      check("timeout_latency", 64'(last_done_cyc - acc_cyc), 17);
      gnt_dly = 0;
      @(posedge clk_i); #1;
      check("timeout_idle", ready_o, 1);
      mem[12'h340] = 64'hF;
      d0 = done_cnt; issue(2'd3, 12'h340, 64'h3, 2'd3, 1'b0); wait_done(d0);
      check("clear_rdata", last_rdata, 64'hF);
      check("clear_written", mem_rd(12'h340), 64'hC);

      // Counters from a clean reset: three reads, two grant-stall cycles each
      rst_ni = 1'b0; @(posedge clk_i); #1 rst_ni = 1'b1;
      gnt_dly = 2;
      for (int k = 0; k < 3; k++) begin
         d0 = done_cnt; issue(2'd0, 12'h340, 64'h0, 2'd3, 1'b0); wait_done(d0);
      end
      @(posedge clk_i); #1;
`ifdef CSR_COMMIT_PERF_EN
      check("perf_ops_3", perf_ops_o, 3);
      check("perf_stall_6", perf_stall_o, 6);
`else
      check("perf_ops_off", perf_ops_o, 0);
      check("perf_stall_off", perf_stall_o, 0);
`endif
      gnt_dly = 0;

      // Asynchronous reset mid-operation
      issue(2'd1, 12'h341, 64'h55, 2'd3, 1'b0);
      #2 rst_ni = 1'b0;
      #1;
      check("midop_reset_ready", ready_o, 1);
      check("midop_reset_req", csr_req_o, 0);
      check("midop_reset_ops", perf_ops_o, 0);
      check("midop_reset_stall", perf_stall_o, 0);
      @(posedge clk_i); #1 rst_ni = 1'b1;
      repeat (6) @(posedge clk_i); #1;
      check("midop_no_write", mem.exists(12'h341) ? 1 : 0, 0);

      // Randomized traffic with variable responder latency
      rnd_resp = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         valid_i    = ($urandom_range(0, 3) != 0);
         commit_i   = ($urandom_range(0, 2) == 0);
         flush_i    = ($urandom_range(0, 7) == 0);
         op_i       = 2'($urandom_range(0, 3));
         addr_i     = addr_tab[$urandom_range(0, 11)];
         wdata_i    = {$urandom, $urandom};
         priv_lvl_i = 2'($urandom_range(0, 3));
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0;
      repeat (60) @(posedge clk_i); #1;
      check("drain_idle", ready_o, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
